// File: rtl/pipe_pkg.sv
// Shared types for the IF/ID pipeline register: occupancy states, the
// fetch entry layout and the drop-counter width.
package pipe_pkg;

    localparam int unsigned IF_INST_W  = 32;
    localparam int unsigned IF_ADDR_W  = 32;
    localparam int unsigned DROP_CNT_W = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_state_e;

    typedef struct packed {
        logic [IF_INST_W-1:0] inst;
        logic [IF_ADDR_W-1:0] pc;
    } if_entry_t;

endpackage

// File: rtl/ifid_skid_if.sv
// Fetch-side and decode-side handshake of the IF/ID register.
// The block itself takes the slave view; the surrounding pipeline takes the master view.
interface ifid_skid_if
    import pipe_pkg::*;
#(
    parameter int unsigned INST_W = IF_INST_W,
    parameter int unsigned ADDR_W = IF_ADDR_W
);
    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] in_inst;
    logic [ADDR_W-1:0] in_pc;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_inst, out_pc
    );

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_inst, out_pc
    );
endinterface

// File: rtl/pipe_slot.sv
// One storage slot of the IF/ID register: a loadable register that can be
// cleared back to zero. Clear wins over load.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter type T = if_entry_t
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic clear_i,
    input  T     d_i,
    output T     q_o
);
    T data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          data_q <= '0;
        else if (clear_i) data_q <= '0;
        else if (load_i)  data_q <= d_i;
    end

    assign q_o = data_q;
endmodule

// File: rtl/ifid_skid.sv
// IF/ID pipeline register with a main + skid slot, registered ready towards
// fetch, and a jump flush followed by a programmable fetch-drop window.
module ifid_skid
    import pipe_pkg::*;
#(
    parameter int unsigned INST_W     = IF_INST_W,
    parameter int unsigned ADDR_W     = IF_ADDR_W,
    parameter int unsigned FLUSH_DROP = 1
) (
    input  logic            clk,
    input  logic            rst,
    ifid_skid_if.slave      bus
);
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    localparam logic [DROP_CNT_W-1:0] DROP_INIT = DROP_CNT_W'(FLUSH_DROP);

    occ_state_e             state_q, state_d;
    logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    entry_t                 fetch, main_d, main_q, skid_q;
    logic                   main_load, main_clear, skid_load, skid_clear;
    logic                   accept, consume, keep;

    // Ready depends only on the occupancy register, never on out_ready.
    assign bus.in_ready  = (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.out_inst  = main_q.inst;
    assign bus.out_pc    = main_q.pc;

    assign fetch   = '{inst: bus.in_inst, pc: bus.in_pc};
    assign accept  = bus.in_valid & bus.in_ready;
    assign consume = bus.out_valid & bus.out_ready;
    assign keep    = accept & (drop_cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        drop_cnt_d = drop_cnt_q;
        main_d     = fetch;
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (bus.flush) begin
            state_d    = EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
            drop_cnt_d = DROP_INIT;
        end else begin
            // The window counts cycles, not fetches, so it closes even if fetch idles.
            if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - 1'b1;
            unique case (state_q)
                EMPTY: begin
                    if (keep) begin
                        state_d   = ONE;
                        main_load = 1'b1;
                    end
                end
                ONE: begin
                    if (keep && !consume) begin
                        state_d   = FULL;
                        skid_load = 1'b1;
                    end else if (keep) begin
                        main_load = 1'b1;
                    end else if (consume) begin
                        state_d    = EMPTY;
                        main_clear = 1'b1;
                    end
                end
                FULL: begin
                    if (consume) begin
                        state_d    = ONE;
                        main_d     = skid_q;
                        main_load  = 1'b1;
                        skid_clear = 1'b1;
                    end
                end
                default: begin
                    state_d    = EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    pipe_slot #(.T(entry_t)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load_i  (main_load),
        .clear_i (main_clear),
        .d_i     (main_d),
        .q_o     (main_q)
    );

    pipe_slot #(.T(entry_t)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .d_i     (fetch),
        .q_o     (skid_q)
    );
endmodule
